addertree_stage2: RTL and testbench

Resolves the bit-column outputs of `addertree_stage1` (weights 2^3..2^18) into a signed 19-bit partial sum, accumulates partial sums over a group of input-channel beats, and requantizes each group result to a signed 8-bit activation. It sits directly downstream of `addertree_stage1` and feeds the activation buffer. The block is a 3-stage pipeline with a valid/ready output handshake.

---
 rtl/npu_pkg.sv | 19 +
 rtl/col_popcount.sv | 43 ++++
 rtl/addertree_stage2.sv | 174 +++++++++++++++++
 tb/tb_addertree_stage2.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// Shared constants for the NPU adder-tree stages: column widths, default
// accumulator width, activation width and a 12-bit popcount helper.
package npu_pkg;

  // Bit-column widths of addertree_stage1 outputs, indexed by weight exponent.
  localparam int AO_W [3:18] = '{6, 8, 9, 10, 10, 11, 12, 11, 10, 9, 7, 5, 5, 3, 2, 1};

  localparam int ACC_W_DEF = 24;
  localparam int ACT_W     = 8;
  localparam int PC_W      = 4;

  function automatic logic [PC_W-1:0] popcount12(input logic [11:0] v);
    logic [PC_W-1:0] n;
    n = '0;
    for (int i = 0; i < 12; i++) n = n + PC_W'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/col_popcount.sv
// Per-column popcount of the addertree_stage1 bit columns (weights 2^3..2^18).
module col_popcount
  import npu_pkg::*;
(
  input  logic [AO_W[3]-1:0]  ao3_i,
  input  logic [AO_W[4]-1:0]  ao4_i,
  input  logic [AO_W[5]-1:0]  ao5_i,
  input  logic [AO_W[6]-1:0]  ao6_i,
  input  logic [AO_W[7]-1:0]  ao7_i,
  input  logic [AO_W[8]-1:0]  ao8_i,
  input  logic [AO_W[9]-1:0]  ao9_i,
  input  logic [AO_W[10]-1:0] ao10_i,
  input  logic [AO_W[11]-1:0] ao11_i,
  input  logic [AO_W[12]-1:0] ao12_i,
  input  logic [AO_W[13]-1:0] ao13_i,
  input  logic [AO_W[14]-1:0] ao14_i,
  input  logic [AO_W[15]-1:0] ao15_i,
  input  logic [AO_W[16]-1:0] ao16_i,
  input  logic [AO_W[17]-1:0] ao17_i,
  input  logic [AO_W[18]-1:0] ao18_i,
  output logic [18:3][PC_W-1:0] pc_o
);

  always_comb begin
    pc_o[3]  = popcount12(12'(ao3_i));
    pc_o[4]  = popcount12(12'(ao4_i));
    pc_o[5]  = popcount12(12'(ao5_i));
    pc_o[6]  = popcount12(12'(ao6_i));
    pc_o[7]  = popcount12(12'(ao7_i));
    pc_o[8]  = popcount12(12'(ao8_i));
    pc_o[9]  = popcount12(12'(ao9_i));
    pc_o[10] = popcount12(12'(ao10_i));
    pc_o[11] = popcount12(12'(ao11_i));
    pc_o[12] = popcount12(12'(ao12_i));
    pc_o[13] = popcount12(12'(ao13_i));
    pc_o[14] = popcount12(12'(ao14_i));
    pc_o[15] = popcount12(12'(ao15_i));
    pc_o[16] = popcount12(12'(ao16_i));
    pc_o[17] = popcount12(12'(ao17_i));
    pc_o[18] = popcount12(12'(ao18_i));
  end

endmodule

// File: rtl/addertree_stage2.sv
// Adder-tree stage 2: popcount -> resolve/accumulate -> requantize, with a
// valid/ready output. Define ADDERTREE_RELU_EN to clamp negative groups to 0.
module addertree_stage2
  import npu_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int SHIFT = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_last,
  input  logic [AO_W[18]-1:0]  ao18,
  input  logic [AO_W[17]-1:0]  ao17,
  input  logic [AO_W[16]-1:0]  ao16,
  input  logic [AO_W[15]-1:0]  ao15,
  input  logic [AO_W[14]-1:0]  ao14,
  input  logic [AO_W[13]-1:0]  ao13,
  input  logic [AO_W[12]-1:0]  ao12,
  input  logic [AO_W[11]-1:0]  ao11,
  input  logic [AO_W[10]-1:0]  ao10,
  input  logic [AO_W[9]-1:0]   ao9,
  input  logic [AO_W[8]-1:0]   ao8,
  input  logic [AO_W[7]-1:0]   ao7,
  input  logic [AO_W[6]-1:0]   ao6,
  input  logic [AO_W[5]-1:0]   ao5,
  input  logic [AO_W[4]-1:0]   ao4,
  input  logic [AO_W[3]-1:0]   ao3,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACT_W-1:0]     out_data,
  output logic [ACC_W-1:0]     out_acc,
  output logic                 out_clip,
  output logic                 out_ovf,
  output logic [7:0]           out_len
);

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W:0]   RND     = (ACC_W+1)'(1) << (SHIFT-1);
  localparam logic signed [ACC_W:0]   QMAX    = (ACC_W+1)'(127);
  localparam logic signed [ACC_W:0]   QMIN    = ~(ACC_W+1)'(127);

  logic en;

  logic [18:3][PC_W-1:0] pc;
  logic [18:3][PC_W-1:0] p1_pc_q;
  logic                  p1_valid_q;
  logic                  p1_last_q;

  logic [18:0]              s19_u;
  logic signed [18:0]       s19;
  logic signed [ACC_W:0]    sum;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     ovf_q, ovf_d;
  logic [7:0]               cnt_q, cnt_d;
  logic                     open_q, open_d;
  logic                     done_q;

  logic signed [ACC_W:0]    acc_x;
  logic signed [ACC_W:0]    rq;
  logic [ACT_W-1:0]         data_d;
  logic                     clip_d;

  logic                     out_valid_q;
  logic [ACT_W-1:0]         out_data_q;
  logic [ACC_W-1:0]         out_acc_q;
  logic                     out_clip_q;
  logic                     out_ovf_q;
  logic [7:0]               out_len_q;

  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;

  col_popcount u_pc (
    .ao3_i (ao3),  .ao4_i (ao4),  .ao5_i (ao5),  .ao6_i (ao6),
    .ao7_i (ao7),  .ao8_i (ao8),  .ao9_i (ao9),  .ao10_i(ao10),
    .ao11_i(ao11), .ao12_i(ao12), .ao13_i(ao13), .ao14_i(ao14),
    .ao15_i(ao15), .ao16_i(ao16), .ao17_i(ao17), .ao18_i(ao18),
    .pc_o  (pc)
  );

  // Resolve: weighted column sum wraps mod 2^19 and is read back as signed.
  always_comb begin
    s19_u = '0;
    for (int k = 3; k <= 18; k++) s19_u = s19_u + (19'(p1_pc_q[k]) << k);
    s19 = signed'(s19_u);
    sum = (ACC_W+1)'(acc_q) + (ACC_W+1)'(s19);

    acc_d  = acc_q;
    ovf_d  = ovf_q;
    cnt_d  = cnt_q;
    open_d = open_q;
    if (p1_valid_q) begin
      open_d = !p1_last_q;
      if (!open_q) begin
        acc_d = ACC_W'(s19);
        ovf_d = 1'b0;
        cnt_d = 8'd1;
      end else begin
        if (sum[ACC_W] != sum[ACC_W-1]) begin
          acc_d = sum[ACC_W] ? ACC_MIN : ACC_MAX;
          ovf_d = 1'b1;
        end else begin
          acc_d = sum[ACC_W-1:0];
        end
        if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_comb begin
    acc_x = (ACC_W+1)'(acc_q);
`ifdef ADDERTREE_RELU_EN
    if (acc_q[ACC_W-1]) acc_x = '0;
`endif
    rq     = (acc_x + RND) >>> SHIFT;
    data_d = rq[ACT_W-1:0];
    clip_d = 1'b0;
    if (rq > QMAX) begin
      data_d = 8'h7F;
      clip_d = 1'b1;
    end else if (rq < QMIN) begin
      data_d = 8'h80;
      clip_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p1_pc_q     <= '0;
      p1_valid_q  <= 1'b0;
      p1_last_q   <= 1'b0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
      open_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_acc_q   <= '0;
      out_clip_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_len_q   <= '0;
    end else if (en) begin
      p1_pc_q     <= pc;
      p1_valid_q  <= in_valid;
      p1_last_q   <= in_last;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      open_q      <= open_d;
      done_q      <= p1_valid_q && p1_last_q;
      // P3 samples the finished group before P2 overwrites it this edge.
      out_valid_q <= done_q;
      if (done_q) begin
        out_data_q <= data_d;
        out_acc_q  <= acc_q;
        out_clip_q <= clip_d;
        out_ovf_q  <= ovf_q;
        out_len_q  <= cnt_q;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_acc   = out_acc_q;
  assign out_clip  = out_clip_q;
  assign out_ovf   = out_ovf_q;
  assign out_len   = out_len_q;

endmodule

// File: tb/tb_addertree_stage2.sv
// Self-checking bench for addertree_stage2: directed vectors, corner sequences
// and randomized groups scored against an arithmetic reference model.
module tb_addertree_stage2;
  import npu_pkg::*;

  localparam int ACC_W = 24;
  localparam int SHIFT = 7;
`ifdef ADDERTREE_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif
  localparam longint AMAX = (longint'(1) << (ACC_W-1)) - 1;
  localparam longint AMIN = -(longint'(1) << (ACC_W-1));

  typedef logic [11:0] cols_t [3:18];
  typedef struct {longint acc; longint data; longint clip; longint ovf; longint len;} res_t;
  typedef struct {int nb; int ca; int va; int cb; int vb;
                  longint acc; longint data; longint clip; longint len;} vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, out_valid, out_clip, out_ovf;
  logic [7:0] out_data, out_len;
  logic [ACC_W-1:0] out_acc;
  cols_t cols;

  int n_pass = 0;
  int n_total = 0;
  res_t exp_q[$];
  bit drv_done = 1'b0;

  always #5 clk = ~clk;

  addertree_stage2 #(.ACC_W(ACC_W), .SHIFT(SHIFT)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .ao18(cols[18][AO_W[18]-1:0]), .ao17(cols[17][AO_W[17]-1:0]),
    .ao16(cols[16][AO_W[16]-1:0]), .ao15(cols[15][AO_W[15]-1:0]),
    .ao14(cols[14][AO_W[14]-1:0]), .ao13(cols[13][AO_W[13]-1:0]),
    .ao12(cols[12][AO_W[12]-1:0]), .ao11(cols[11][AO_W[11]-1:0]),
    .ao10(cols[10][AO_W[10]-1:0]), .ao9(cols[9][AO_W[9]-1:0]),
    .ao8(cols[8][AO_W[8]-1:0]),    .ao7(cols[7][AO_W[7]-1:0]),
    .ao6(cols[6][AO_W[6]-1:0]),    .ao5(cols[5][AO_W[5]-1:0]),
    .ao4(cols[4][AO_W[4]-1:0]),    .ao3(cols[3][AO_W[3]-1:0]),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_acc(out_acc), .out_clip(out_clip), .out_ovf(out_ovf), .out_len(out_len)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    else n_pass++;
  endtask

  task automatic fail_to(input string nm);
    n_total++;
    $display("FAIL %s: got timeout expected DUT event", nm);
  endtask

  function automatic cols_t zero_cols();
    cols_t c;
    for (int k = 3; k <= 18; k++) c[k] = '0;
    return c;
  endfunction

  // Column value of one beat: popcount-weighted sum, wrapped to signed 19 bits.
  function automatic longint beat_val(input cols_t c);
    longint v;
    v = 0;
    for (int k = 3; k <= 18; k++) v += longint'($countones(c[k])) * (longint'(1) << k);
    v = v % (longint'(1) << 19);
    if (v >= (longint'(1) << 18)) v -= (longint'(1) << 19);
    return v;
  endfunction

  function automatic res_t model(input longint vals[$]);
    res_t r;
    longint a, q;
    r.acc = 0;
    r.ovf = 0;
    foreach (vals[i]) begin
      if (i == 0) r.acc = vals[i];
      else begin
        r.acc += vals[i];
        if (r.acc > AMAX) begin r.acc = AMAX; r.ovf = 1; end
        if (r.acc < AMIN) begin r.acc = AMIN; r.ovf = 1; end
      end
    end
    r.len = (vals.size() > 255) ? 255 : vals.size();
    a = (RELU && r.acc < 0) ? 0 : r.acc;
    q = (a + (longint'(1) << (SHIFT-1))) >>> SHIFT;
    r.clip = 0;
    if (q > 127) begin q = 127; r.clip = 1; end
    else if (q < -128) begin q = -128; r.clip = 1; end
    r.data = q;
    return r;
  endfunction

  task automatic chk_res(input string nm, input res_t e);
    chk({nm, "_acc"},  longint'($signed(out_acc)), e.acc);
    chk({nm, "_data"}, longint'($signed(out_data)), e.data);
    chk({nm, "_clip"}, longint'(out_clip), e.clip);
    chk({nm, "_ovf"},  longint'(out_ovf), e.ovf);
    chk({nm, "_len"},  longint'(out_len), e.len);
  endtask

  task automatic send_beat(input cols_t c, input bit last);
    bit take;
    int guard;
    guard = 0;
    @(negedge clk);
    cols = c;
    in_valid = 1'b1;
    in_last = last;
    forever begin
      #2;
      take = in_ready;
      @(posedge clk);
      if (take) break;
      guard++;
      if (guard > 2000) begin fail_to("accept"); break; end
      @(negedge clk);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    if (!out_valid) fail_to(nm);
  endtask

  task automatic send_rep(input int n, input int col, input int val);
    cols_t c;
    c = zero_cols();
    c[col] = 12'(val);
    for (int i = 0; i < n; i++) send_beat(c, i == n-1);
    idle();
  endtask

  initial begin
    vec_t tbl [10];
    cols_t c;
    res_t e;
    int nres;
    longint got_acc, got_len;
    longint accs[$];
    int cycs[$];

    cols = zero_cols();
    tbl = '{
      '{1,  7, 'h001,  0, 0,     128,   1,               0,             1},
      '{2, 12, 'h1FF,  0, 0,   73728, 127,               1,             2},
      '{1, 18, 'h001,  0, 0, -262144, RELU ? 0 : -128,   RELU ? 0 : 1,  1},
      '{1, 10, 'h001,  0, 0,    1024,   8,               0,             1},
      '{1,  3, 'h03F,  0, 0,      48,   0,               0,             1},
      '{3,  9, 'hFFF,  0, 0,   18432, 127,               1,             3},
      '{1,  6, 'h001,  0, 0,      64,   1,               0,             1},
      '{2,  5, 'h001,  0, 0,      64,   1,               0,             2},
      '{1, 18, 'h001, 17, 1, -131072, RELU ? 0 : -128,   RELU ? 0 : 1,  1},
      '{1,  6, 'h3FF,  4, 'hFF,  768,   6,               0,             1}
    };

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_acc", out_acc, 0);
    chk("rst_clip", out_clip, 0);
    chk("rst_ovf", out_ovf, 0);
    chk("rst_len", out_len, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    reset = 1'b1;
    out_ready = 1'b1;

    // Latency: beat sampled on edge 1, result visible after edge 3
    c = zero_cols();
    c[7] = 12'h001;
    @(negedge clk);
    cols = c; in_valid = 1'b1; in_last = 1'b1;
    @(posedge clk); #1; chk("lat_e1_valid", out_valid, 0);
    @(negedge clk); in_valid = 1'b0; in_last = 1'b0;
    @(posedge clk); #1; chk("lat_e2_valid", out_valid, 0);
    @(posedge clk); #1; chk("lat_e3_valid", out_valid, 1);
    chk("lat_acc", longint'($signed(out_acc)), 128);
    chk("lat_data", longint'($signed(out_data)), 1);
    chk("lat_len", out_len, 1);
    @(posedge clk); #1; chk("lat_e4_valid", out_valid, 0);

    // Directed table
    for (int i = 0; i < 10; i++) begin
      c = zero_cols();
      c[tbl[i].ca] = 12'(tbl[i].va);
      if (tbl[i].cb != 0) c[tbl[i].cb] = 12'(tbl[i].vb);
      for (int b = 0; b < tbl[i].nb; b++) send_beat(c, b == tbl[i].nb-1);
      idle();
      wait_valid($sformatf("vec%0d_wait", i));
      e.acc = tbl[i].acc; e.data = tbl[i].data; e.clip = tbl[i].clip;
      e.ovf = 0; e.len = tbl[i].len;
      chk_res($sformatf("vec%0d", i), e);
    end

    // Positive saturation, then stickiness of ovf after coming back in range
    send_rep(43, 16, 'h7);
    wait_valid("ovfp_wait");
    e = '{acc: AMAX, data: 127, clip: 1, ovf: 1, len: 43};
    chk_res("ovfp", e);
    c = zero_cols(); c[16] = 12'h007;
    for (int i = 0; i < 43; i++) send_beat(c, 1'b0);
    c = zero_cols(); c[18] = 12'h001;
    send_beat(c, 1'b1);
    idle();
    wait_valid("sticky_wait");
    e = '{acc: 8126463, data: 127, clip: 1, ovf: 1, len: 44};
    chk_res("sticky", e);

    // Negative limit reached exactly (no ovf), then exceeded
    send_rep(32, 18, 1);
    wait_valid("negmin_wait");
    e = '{acc: AMIN, data: RELU ? 0 : -128, clip: RELU ? 0 : 1, ovf: 0, len: 32};
    chk_res("negmin", e);
    send_rep(33, 18, 1);
    wait_valid("ovfn_wait");
    e.ovf = 1; e.len = 33;
    chk_res("ovfn", e);

    // Beat counter saturates at 255
    send_rep(300, 3, 1);
    wait_valid("len_wait");
    e = '{acc: 2400, data: 19, clip: 0, ovf: 0, len: 255};
    chk_res("lensat", e);

    // Backpressure: result A pending, group B frozen inside the pipeline
    repeat (3) @(posedge clk);
    @(negedge clk); out_ready = 1'b0;
    c = zero_cols(); c[10] = 12'h001; send_beat(c, 1'b1);
    c = zero_cols(); c[7] = 12'h001;  send_beat(c, 1'b1);
    idle();
    wait_valid("stall_wait");
    for (int i = 0; i < 5; i++) begin
      chk("stall_in_ready", in_ready, 0);
      chk("stall_valid", out_valid, 1);
      chk("stall_acc", longint'($signed(out_acc)), 1024);
      chk("stall_data", longint'($signed(out_data)), 8);
      chk("stall_len", out_len, 1);
      @(posedge clk); #1;
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_valid", out_valid, 1);
    chk("release_acc", longint'($signed(out_acc)), 128);
    chk("release_data", longint'($signed(out_data)), 1);
    @(posedge clk); #1;
    chk("release_drain", out_valid, 0);

    // Back-to-back single-beat groups: one result per cycle
    repeat (2) @(posedge clk);
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          cols = zero_cols();
          cols[(i == 0) ? 10 : (i == 1) ? 7 : (i == 2) ? 3 : 12] = 12'h001;
          in_valid = 1'b1; in_last = 1'b1;
        end
        @(negedge clk); in_valid = 1'b0; in_last = 1'b0;
      end
      begin
        for (int cyc = 0; cyc < 12; cyc++) begin
          @(posedge clk); #1;
          if (out_valid) begin accs.push_back(longint'($signed(out_acc))); cycs.push_back(cyc); end
        end
      end
    join
    chk("b2b_count", accs.size(), 4);
    if (accs.size() == 4) begin
      chk("b2b_acc0", accs[0], 1024);
      chk("b2b_acc1", accs[1], 128);
      chk("b2b_acc2", accs[2], 8);
      chk("b2b_acc3", accs[3], 4096);
      for (int i = 1; i < 4; i++) chk("b2b_spacing", cycs[i] - cycs[0], i);
    end

    // Reset mid-group discards the partial group
    c = zero_cols(); c[12] = 12'h1FF;
    send_beat(c, 1'b0);
    @(negedge clk); in_valid = 1'b0; reset = 1'b0;
    @(posedge clk); #1; chk("rstmid_valid", out_valid, 0);
    @(negedge clk); reset = 1'b1;
    c = zero_cols(); c[10] = 12'h001;
    send_beat(c, 1'b1);
    idle();
    nres = 0; got_acc = 0; got_len = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        nres++;
        got_acc = longint'($signed(out_acc));
        got_len = out_len;
      end
    end
    chk("rstmid_count", nres, 1);
    chk("rstmid_acc", got_acc, 1024);
    chk("rstmid_len", got_len, 1);

    // Randomized groups with random bubbles and backpressure
    fork
      begin
        for (int g = 0; g < 150; g++) begin
          cols_t beats [5];
          longint vals[$];
          int nb;
          bit sparse;
          nb = $urandom_range(1, 5);
          vals = {};
          for (int b = 0; b < nb; b++) begin
            sparse = ($urandom_range(0, 1) == 1);
            for (int k = 3; k <= 18; k++) begin
              beats[b][k] = 12'($urandom) & 12'((1 << AO_W[k]) - 1);
              if (sparse && k >= 9) beats[b][k] = '0;
            end
            vals.push_back(beat_val(beats[b]));
          end
          exp_q.push_back(model(vals));
          for (int b = 0; b < nb; b++) begin
            if ($urandom_range(0, 3) == 0) idle();
            send_beat(beats[b], b == nb-1);
          end
        end
        idle();
        drv_done = 1'b1;
      end
      begin
        int budget;
        res_t r;
        budget = 0;
        while (!(drv_done && exp_q.size() == 0) && budget < 20000) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 9) < 7);
          #1;
          if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
              chk("rand_unexpected", 1, 0);
            end else begin
              r = exp_q.pop_front();
              chk_res("rand", r);
            end
          end
          budget++;
        end
        if (budget >= 20000) fail_to("rand_drain");
        out_ready = 1'b1;
      end
    join

    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
